// File: rtl/inst_queue_pkg.sv
// ----------------------------------------------------------------------------
// inst_queue_pkg
//   Shared definitions for the dual-issue instruction queue: default geometry,
//   dequeue-count width, fetch-mask encoding and small helper functions.
//   Imported by inst_queue and inst_queue_ram.
// ----------------------------------------------------------------------------
package inst_queue_pkg;

    // Default queue geometry
    localparam int INSTQ_DEPTH  = 8;
    localparam int INSTQ_PC_W   = 32;
    localparam int INSTQ_INST_W = 32;

    // Dequeue count: 0, 1 or 2 entries per cycle (3 behaves as 2)
    localparam int DEQ_CNT_W = 2;

    // Fetch-group word usability mask
    typedef enum logic [1:0] {
        MASK_NONE = 2'b00,
        MASK_LO   = 2'b01,
        MASK_HI   = 2'b10,
        MASK_BOTH = 2'b11
    } fetch_mask_e;

    // Requests above two are treated as two
    function automatic logic [DEQ_CNT_W-1:0] clamp_deq(input logic [DEQ_CNT_W-1:0] d);
        return (d == 2'd3) ? 2'd2 : d;
    endfunction

    // Number of usable words in a fetch group
    function automatic logic [1:0] mask_count(input logic [1:0] m);
        return {1'b0, m[0]} + {1'b0, m[1]};
    endfunction

endpackage

// File: rtl/inst_queue_ram.sv
// ----------------------------------------------------------------------------
// inst_queue_ram
//   DEPTH x {pc, npc, inst} storage for the instruction queue. npc is derived
//   at write time as pc + 4. Two write ports, two asynchronous read ports,
//   whole array cleared by the asynchronous active-low reset.
//
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   we0/waddr0/wpc0/winst0 write port 0
//   we1/waddr1/wpc1/winst1 write port 1 (never the same address as port 0)
//   raddr0 -> rpc0/rnpc0/rinst0   read port 0
//   raddr1 -> rpc1/rnpc1/rinst1   read port 1
// ----------------------------------------------------------------------------
module inst_queue_ram
    import inst_queue_pkg::*;
#(
    parameter int DEPTH  = INSTQ_DEPTH,
    parameter int PC_W   = INSTQ_PC_W,
    parameter int INST_W = INSTQ_INST_W,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we0,
    input  logic [AW-1:0]     waddr0,
    input  logic [PC_W-1:0]   wpc0,
    input  logic [INST_W-1:0] winst0,
    input  logic              we1,
    input  logic [AW-1:0]     waddr1,
    input  logic [PC_W-1:0]   wpc1,
    input  logic [INST_W-1:0] winst1,
    input  logic [AW-1:0]     raddr0,
    output logic [PC_W-1:0]   rpc0,
    output logic [PC_W-1:0]   rnpc0,
    output logic [INST_W-1:0] rinst0,
    input  logic [AW-1:0]     raddr1,
    output logic [PC_W-1:0]   rpc1,
    output logic [PC_W-1:0]   rnpc1,
    output logic [INST_W-1:0] rinst1
);

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [PC_W-1:0]   npc_mem  [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                npc_mem[i]  <= '0;
                inst_mem[i] <= '0;
            end
        end else begin
            if (we0) begin
                pc_mem[waddr0]   <= wpc0;
                npc_mem[waddr0]  <= wpc0 + PC_W'(4);
                inst_mem[waddr0] <= winst0;
            end
            if (we1) begin
                pc_mem[waddr1]   <= wpc1;
                npc_mem[waddr1]  <= wpc1 + PC_W'(4);
                inst_mem[waddr1] <= winst1;
            end
        end
    end

    assign rpc0   = pc_mem[raddr0];
    assign rnpc0  = npc_mem[raddr0];
    assign rinst0 = inst_mem[raddr0];
    assign rpc1   = pc_mem[raddr1];
    assign rnpc1  = npc_mem[raddr1];
    assign rinst1 = inst_mem[raddr1];

endmodule

// File: rtl/inst_queue.sv
// ----------------------------------------------------------------------------
// inst_queue
//   Dual-issue instruction queue between fetch and the two decoders. Accepts
//   up to two instructions per cycle from a 64-bit fetch group, keeps them in
//   program order in a circular FIFO and presents the two oldest entries.
//   Retires 0/1/2 entries per cycle; a branch redirect (flush) empties it.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   in_valid/in_pc/in_inst/in_mask fetch group; in_inst[31:0] at in_pc,
//                                 in_inst[63:32] at in_pc+4; mask bit per word
//   in_ready                      queue can take a full group this cycle
//   flush                         redirect; clears pointers and count
//   deq_cnt                       entries consumed this cycle (3 acts as 2)
//   out1_*/out2_*                 oldest / second-oldest entry
//   count                         current occupancy
//
// Build option:
//   INSTQ_LATE_READY_EN  credit same-cycle pops in in_ready (combinational
//                        path deq_cnt -> in_ready).
// ----------------------------------------------------------------------------
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH  = INSTQ_DEPTH,
    parameter int PC_W   = INSTQ_PC_W,
    parameter int INST_W = INSTQ_INST_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [2*INST_W-1:0]      in_inst,
    input  logic [1:0]               in_mask,
    output logic                     in_ready,
    input  logic                     flush,
    input  logic [DEQ_CNT_W-1:0]     deq_cnt,
    output logic                     out1_valid,
    output logic [PC_W-1:0]          out1_pc,
    output logic [PC_W-1:0]          out1_npc,
    output logic [INST_W-1:0]        out1_inst,
    output logic                     out2_valid,
    output logic [PC_W-1:0]          out2_pc,
    output logic [PC_W-1:0]          out2_npc,
    output logic [INST_W-1:0]        out2_inst,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]        rd_ptr;
    logic [AW-1:0]        wr_ptr;
    logic [DEQ_CNT_W-1:0] deq_clamped;
    logic [1:0]           pop_n;
    logic [1:0]           push_n;
    logic                 push_en;
    logic [CW-1:0]        count_nxt;

    logic                 we0;
    logic                 we1;
    logic [AW-1:0]        waddr0;
    logic [AW-1:0]        waddr1;
    logic [PC_W-1:0]      wpc0;
    logic [PC_W-1:0]      wpc1;
    logic [INST_W-1:0]    winst0;
    logic [INST_W-1:0]    winst1;

    // Pop never exceeds occupancy; when it would, count is at most 1.
    assign deq_clamped = clamp_deq(deq_cnt);
    assign pop_n = ({{(CW-2){1'b0}}, deq_clamped} > count) ? count[1:0] : deq_clamped;

`ifdef INSTQ_LATE_READY_EN
    // Free slots after this cycle's pops must hold a full group.
    assign in_ready = (count <= (CW'(DEPTH - 2) + {{(CW-2){1'b0}}, pop_n}));
`else
    assign in_ready = (count <= CW'(DEPTH - 2));
`endif

    assign push_en   = in_valid & in_ready & ~flush;
    assign push_n    = push_en ? mask_count(in_mask) : 2'd0;
    assign count_nxt = count + CW'(push_n) - CW'(pop_n);

    // A single usable word always goes through port 0 at wr_ptr; the high
    // word of a full group goes through port 1 at wr_ptr+1.
    always_comb begin
        we0    = 1'b0;
        we1    = 1'b0;
        waddr0 = wr_ptr;
        waddr1 = wr_ptr + AW'(1);
        wpc0   = in_pc;
        winst0 = in_inst[INST_W-1:0];
        wpc1   = in_pc + PC_W'(4);
        winst1 = in_inst[2*INST_W-1:INST_W];
        if (push_en) begin
            case (in_mask)
                MASK_BOTH: begin
                    we0 = 1'b1;
                    we1 = 1'b1;
                end
                MASK_LO: begin
                    we0 = 1'b1;
                end
                MASK_HI: begin
                    we0    = 1'b1;
                    wpc0   = in_pc + PC_W'(4);
                    winst0 = in_inst[2*INST_W-1:INST_W];
                end
                default: begin
                end
            endcase
        end
    end

    // Pointer / occupancy register stage; flush wins over push and pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(pop_n);
            wr_ptr <= wr_ptr + AW'(push_n);
            count  <= count_nxt;
        end
    end

    inst_queue_ram #(
        .DEPTH  (DEPTH),
        .PC_W   (PC_W),
        .INST_W (INST_W),
        .AW     (AW)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .we0    (we0),
        .waddr0 (waddr0),
        .wpc0   (wpc0),
        .winst0 (winst0),
        .we1    (we1),
        .waddr1 (waddr1),
        .wpc1   (wpc1),
        .winst1 (winst1),
        .raddr0 (rd_ptr),
        .rpc0   (out1_pc),
        .rnpc0  (out1_npc),
        .rinst0 (out1_inst),
        .raddr1 (rd_ptr + AW'(1)),
        .rpc1   (out2_pc),
        .rnpc1  (out2_npc),
        .rinst1 (out2_inst)
    );

    assign out1_valid = (count != '0);
    assign out2_valid = (count >= CW'(2));

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0;
    logic [63:0] in_inst = '0;
    logic [1:0]  in_mask = '0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic [1:0]  deq_cnt = '0;
    logic        out1_valid, out2_valid;
    logic [31:0] out1_pc, out1_npc, out1_inst;
    logic [31:0] out2_pc, out2_npc, out2_inst;
    logic [3:0]  count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] inst;
    } ent_t;

    ent_t q[$];

    always #5 clk = ~clk;

    inst_queue #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_pc      (in_pc),
        .in_inst    (in_inst),
        .in_mask    (in_mask),
        .in_ready   (in_ready),
        .flush      (flush),
        .deq_cnt    (deq_cnt),
        .out1_valid (out1_valid),
        .out1_pc    (out1_pc),
        .out1_npc   (out1_npc),
        .out1_inst  (out1_inst),
        .out2_valid (out2_valid),
        .out2_pc    (out2_pc),
        .out2_npc   (out2_npc),
        .out2_inst  (out2_inst),
        .count      (count)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entries actually retired this cycle by the queue's rules
    function automatic int model_pop();
        int d;
        d = (deq_cnt == 2'd3) ? 2 : int'(deq_cnt);
        return (d < q.size()) ? d : q.size();
    endfunction

    function automatic logic model_ready();
        int free;
        free = DEPTH - q.size();
`ifdef INSTQ_LATE_READY_EN
        free += model_pop();
`endif
        return (free >= 2);
    endfunction

    task automatic check_outputs();
        chk("count", 64'(count), 64'(q.size()));
        chk("out1_valid", 64'(out1_valid), 64'(q.size() >= 1));
        chk("out2_valid", 64'(out2_valid), 64'(q.size() >= 2));
        chk("in_ready", 64'(in_ready), 64'(model_ready()));
        if (q.size() >= 1) begin
            chk("out1_pc", 64'(out1_pc), 64'(q[0].pc));
            chk("out1_npc", 64'(out1_npc), 64'(q[0].npc));
            chk("out1_inst", 64'(out1_inst), 64'(q[0].inst));
        end
        if (q.size() >= 2) begin
            chk("out2_pc", 64'(out2_pc), 64'(q[1].pc));
            chk("out2_npc", 64'(out2_npc), 64'(q[1].npc));
            chk("out2_inst", 64'(out2_inst), 64'(q[1].inst));
        end
    endtask

    task automatic model_update();
        logic rdy;
        int   p;
        ent_t e;
        rdy = model_ready();
        if (flush) begin
            q.delete();
        end else begin
            p = model_pop();
            repeat (p) void'(q.pop_front());
            if (in_valid && rdy) begin
                if (in_mask[0]) begin
                    e.pc = in_pc; e.npc = in_pc + 32'd4; e.inst = in_inst[31:0];
                    q.push_back(e);
                end
                if (in_mask[1]) begin
                    e.pc = in_pc + 32'd4; e.npc = in_pc + 32'd8; e.inst = in_inst[63:32];
                    q.push_back(e);
                end
            end
        end
    endtask

    // Called at a falling edge: drive, check pre-edge state, clock, update model.
    task automatic step(input logic v, input logic [31:0] pc, input logic [63:0] inst,
                        input logic [1:0] m, input logic [1:0] d, input logic f);
        in_valid = v; in_pc = pc; in_inst = inst; in_mask = m; deq_cnt = d; flush = f;
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 64'h0, 2'b00, 2'd0, 1'b0);
    endtask

    task automatic do_flush();
        step(1'b0, 32'h0, 64'h0, 2'b00, 2'd0, 1'b1);
    endtask

    logic [31:0] head_pc;
    logic [31:0] push_pc;

    initial begin
        // Reset: everything reads zero, ready high
        #2;
        chk("rst_count", 64'(count), 64'h0);
        chk("rst_out1_valid", 64'(out1_valid), 64'h0);
        chk("rst_out2_valid", 64'(out2_valid), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        chk("rst_out1_pc", 64'(out1_pc), 64'h0);
        chk("rst_out1_npc", 64'(out1_npc), 64'h0);
        chk("rst_out1_inst", 64'(out1_inst), 64'h0);
        chk("rst_out2_pc", 64'(out2_pc), 64'h0);
        chk("rst_out2_npc", 64'(out2_npc), 64'h0);
        chk("rst_out2_inst", 64'(out2_inst), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 1: full group at 0x100
        step(1'b1, 32'h100, {32'hBBBB_0002, 32'hAAAA_0001}, 2'b11, 2'd0, 1'b0);
        chk("t1_count", 64'(count), 64'd2);
        chk("t1_out1_pc", 64'(out1_pc), 64'h100);
        chk("t1_out1_npc", 64'(out1_npc), 64'h104);
        chk("t1_out1_inst", 64'(out1_inst), 64'hAAAA_0001);
        chk("t1_out2_pc", 64'(out2_pc), 64'h104);
        chk("t1_out2_npc", 64'(out2_npc), 64'h108);
        chk("t1_out2_inst", 64'(out2_inst), 64'hBBBB_0002);

        // 2: fill toward full, hold a group, then drain with deq_cnt=2
        step(1'b1, 32'h108, {32'h1111_0004, 32'h1111_0003}, 2'b11, 2'd0, 1'b0);
        step(1'b1, 32'h110, {32'h1111_0006, 32'h1111_0005}, 2'b11, 2'd0, 1'b0);
        step(1'b1, 32'h118, {32'h1111_0008, 32'h1111_0007}, 2'b01, 2'd0, 1'b0);
        chk("t2_count7", 64'(count), 64'd7);
        chk("t2_ready_at7", 64'(in_ready), 64'h0);
        repeat (3) step(1'b1, 32'h120, {32'h2222_0002, 32'h2222_0001}, 2'b11, 2'd0, 1'b0);
        step(1'b1, 32'h120, {32'h2222_0002, 32'h2222_0001}, 2'b11, 2'd2, 1'b0);
        step(1'b1, 32'h120, {32'h2222_0002, 32'h2222_0001}, 2'b11, 2'd0, 1'b0);
        idle();

        // 3: high word only
        do_flush();
        step(1'b1, 32'h200, {32'hCCCC_0003, 32'hDDDD_0004}, 2'b10, 2'd0, 1'b0);
        chk("t3_count", 64'(count), 64'd1);
        chk("t3_out1_pc", 64'(out1_pc), 64'h204);
        chk("t3_out1_npc", 64'(out1_npc), 64'h208);
        chk("t3_out1_inst", 64'(out1_inst), 64'hCCCC_0003);
        chk("t3_out2_valid", 64'(out2_valid), 64'h0);

        // 4: over-request on a single entry
        step(1'b0, 32'h0, 64'h0, 2'b00, 2'd3, 1'b0);
        chk("t4_count", 64'(count), 64'd0);
        chk("t4_out1_valid", 64'(out1_valid), 64'h0);
        step(1'b0, 32'h0, 64'h0, 2'b00, 2'd3, 1'b0);
        step(1'b1, 32'h240, {32'h4444_0002, 32'h4444_0001}, 2'b01, 2'd0, 1'b0);
        chk("t4_after_pc", 64'(out1_pc), 64'h240);

        // 5: flush beats simultaneous push and pop
        do_flush();
        step(1'b1, 32'h300, {32'h5555_0002, 32'h5555_0001}, 2'b11, 2'd0, 1'b0);
        step(1'b1, 32'h308, {32'h5555_0004, 32'h5555_0003}, 2'b11, 2'd0, 1'b0);
        step(1'b1, 32'h310, {32'h5555_0006, 32'h5555_0005}, 2'b01, 2'd0, 1'b0);
        chk("t5_count5", 64'(count), 64'd5);
        step(1'b1, 32'h380, {32'h6666_0002, 32'h6666_0001}, 2'b11, 2'd2, 1'b1);
        chk("t5_count", 64'(count), 64'd0);
        chk("t5_out1_valid", 64'(out1_valid), 64'h0);
        chk("t5_out2_valid", 64'(out2_valid), 64'h0);
        idle();

        // 6: wrap with steady push-2/pop-2
        do_flush();
        push_pc = 32'h0;
        head_pc = 32'h0;
        step(1'b1, push_pc, {$urandom, $urandom}, 2'b11, 2'd0, 1'b0);
        push_pc += 32'd8;
`ifdef INSTQ_LATE_READY_EN
        repeat (3) begin
            step(1'b1, push_pc, {$urandom, $urandom}, 2'b11, 2'd0, 1'b0);
            push_pc += 32'd8;
        end
        chk("t6_count_full", 64'(count), 64'd8);
        in_valid = 1'b1; in_mask = 2'b11; deq_cnt = 2'd2; flush = 1'b0;
        #1;
        chk("t6_late_ready_full", 64'(in_ready), 64'h1);
`endif
        for (int k = 0; k < 20; k++) begin
            step(1'b1, push_pc, {$urandom, $urandom}, 2'b11, 2'd2, 1'b0);
            push_pc += 32'd8;
            head_pc += 32'd8;
            chk("t6_wrap_pc", 64'(out1_pc), 64'(head_pc));
        end

        // Randomized traffic against the queue model
        do_flush();
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 3) != 0),
                 $urandom & 32'hFFFF_FFFC,
                 {$urandom, $urandom},
                 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 24) == 0));
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
Dual-issue instruction queue between fetch and the two decoders. It replaces the IF/ID pipeline register.
- Accepts up to two 32-bit instructions per cycle from the 64-bit fetch group.
- Buffers them in program order in a circular FIFO.
- Presents the two oldest entries (pc, npc, inst) to DECODE_1 and DECODE_2.
- Retires 0, 1 or 2 entries per cycle, as reported by the launch-select logic.
- A branch redirect flushes the whole queue.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 4.
- PC_W, 32, width of pc and npc.
- INST_W, 32, instruction width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch group valid.
- in_pc  in  PC_W  address of the low word of the fetch group.
- in_inst  in  2*INST_W  [31:0] is the instruction at in_pc; [63:32] is the instruction at in_pc+4.
- in_mask  in  2  bit0 = low word usable, bit1 = high word usable.
- in_ready  out  1  queue can accept a fetch group this cycle.
- flush  in  1  branch redirect; empties the queue.
- deq_cnt  in  2  number of entries consumed this cycle (0/1/2; 3 is treated as 2).
- out1_valid  out  1  head entry valid.
- out1_pc  out  PC_W  head entry pc.
- out1_npc  out  PC_W  head entry npc.
- out1_inst  out  INST_W  head entry instruction.
- out2_valid  out  1  second entry valid.
- out2_pc  out  PC_W  second entry pc.
- out2_npc  out  PC_W  second entry npc.
- out2_inst  out  INST_W  second entry instruction.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst=0, asynchronous):
  - read pointer, write pointer and count cleared to 0.
  - all entry storage cleared to 0.
  - out1/out2 valid, pc, npc and inst all read 0.
  - in_ready reads 1.
- Storage: DEPTH entries of {pc, npc, inst}; npc = pc + 4, modulo 2^PC_W.
- Outputs are combinational from storage:
  - out1 shows entry[rd_ptr]; out2 shows entry[rd_ptr+1 mod DEPTH].
  - out1_valid = (count >= 1); out2_valid = (count >= 2).
  - Data on an invalid output reads as stale storage; consumers must ignore it.
- in_ready = (DEPTH - count >= 2). It depends on registered count only, with no same-cycle pop credit.
- Push happens when in_valid & in_ready & !flush:
  - in_mask 2'b11: low word written at wr_ptr, high word at wr_ptr+1; wr_ptr += 2.
  - in_mask 2'b01: low word only (pc = in_pc); wr_ptr += 1.
  - in_mask 2'b10: high word only (pc = in_pc + 4); wr_ptr += 1.
  - in_mask 2'b00: no write.
- Pop:
  - effective pop = min(deq_cnt clamped to 2, count), evaluated on the pre-edge count.
  - rd_ptr += pop.
  - Over-request never underflows.
- Simultaneous push and pop: count_next = count + push_n - pop_n. Both pointers wrap modulo DEPTH.
- Flush has priority over everything:
  - next edge sets rd_ptr = wr_ptr = 0 and count = 0.
  - a same-cycle push is dropped and a same-cycle pop is ignored.
  - storage contents are not cleared.
- Latency: an entry pushed at edge N is visible on out1/out2 in the cycle after edge N. There is no bypass when the queue is empty.
- Full: with count = DEPTH-1 or DEPTH, in_ready = 0 and fetch must hold its group.
- Empty: out1_valid = out2_valid = 0, and deq_cnt is ignored.

Optional Feature:
- Macro INSTQ_LATE_READY_EN.
- Defined: in_ready = (DEPTH - count + pop_n >= 2), which credits same-cycle pops. This creates a combinational path from deq_cnt to in_ready, but a full queue popping 2 can still accept a group.
- Undefined: in_ready uses registered count only, as described above.

Decomposition:
- Shared def.vh gains:
  - INSTQ_DEPTH default.
  - width macros for the deq count.
  - entry field positions, if packed.
- Existing PC_BUS, DATA_BUS and PC_INITIAL macros are reused.
- One sub-module is natural: inst_queue_ram.
  - Holds the DEPTH x {pc, npc, inst} array.
  - Two write ports and two read ports, with asynchronous reset.
  - Pointer and count logic stays in the parent.

Test Plan:
1. Reset, then push pc=0x100 with mask 11 (inst A, B):
   - next cycle: out1 = {0x100, 0x104, A}, out2 = {0x104, 0x108, B}, count = 2.
2. Fill to DEPTH=8 with deq_cnt=0:
   - in_ready drops once count = 7 or 8.
   - a held group is accepted only after deq_cnt=2 drains the queue.
3. Push mask 10 at pc=0x200 (inst C):
   - only entry {0x204, 0x208, C} is written; count += 1.
4. count=1 with deq_cnt=3:
   - pops 1; count = 0; both valids 0; pointers stay consistent.
5. count=5 with flush=1, in_valid=1, deq_cnt=2 in the same cycle:
   - count = 0, valids 0, and the pushed group does not appear.
6. Wrap test:
   - 20 consecutive cycles of push-2/pop-2 with DEPTH=8.
   - out1_pc follows 0x0, 0x8, 0x10, ... with no loss or reorder.
   - with INSTQ_LATE_READY_EN, in_ready stays 1 at count=8 while deq_cnt=2.
